// File: rtl/counter_down_pkg.sv
// Shared definitions for the down-counter family: FSM state encodings
// reused by counter blocks built on the same RUN/DONE control scheme.
package counter_down_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

endpackage

// File: rtl/counter_down_ctrl.sv
// Control FSM for counter_down: decides decrement/wrap each edge and owns
// the registered borrow pulse and sticky done flag.
module counter_down_ctrl
  import counter_down_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic       auto_reload,
  input  logic       count_zero,
  output logic       dec,
  output logic       wrap,
  output logic       borrow,
  output logic       done,
  output logic [0:0] state
);

  state_t state_q;

  // load takes priority over en; in DONE the enable is ignored.
  logic step;
  assign step  = (state_q == ST_RUN) && en && !load;
  assign dec   = step && !count_zero;
  assign wrap  = step && count_zero && auto_reload;
  assign state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      borrow  <= 1'b0;
      done    <= 1'b0;
    end else if (load) begin
      state_q <= ST_RUN;
      borrow  <= 1'b0;
      done    <= 1'b0;
    end else if (step && count_zero) begin
      if (auto_reload) begin
        borrow <= 1'b1;
      end else begin
        state_q <= ST_DONE;
        done    <= 1'b1;
        borrow  <= 1'b0;
      end
    end else begin
      borrow <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_down.sv
// Loadable down counter with optional auto-reload or one-shot stop at zero.
// Datapath (count, reload register) lives here; sequencing is in the ctrl.
module counter_down
  import counter_down_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RELOAD_INIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow,
  output logic             done,
  output logic [0:0]       fsm_state
);

  logic [WIDTH-1:0] reload_q;
  logic             dec;
  logic             wrap;

  assign zero = (count == '0);

  counter_down_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .auto_reload (auto_reload),
    .count_zero  (zero),
    .dec         (dec),
    .wrap        (wrap),
    .borrow      (borrow),
    .done        (done),
    .state       (fsm_state)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      reload_q <= RELOAD_INIT;
    end else if (load) begin
      count    <= din;
      reload_q <= din;
    end else if (wrap) begin
      count <= reload_q;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

endmodule
